sync_fifo_thr: RTL

- Single-clock parametrised FIFO with occupancy count and programmable almost-full/almost-empty thresholds.
- Registered read port with 1-cycle latency.
- Next-generation replacement for the fixed-depth FIFO used between the minilab datapath stages.
- Feeds MAC/accumulator stages that need early back-pressure and fill-level visibility.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_mem.sv | 31 +++
 rtl/sync_fifo_thr.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the threshold FIFO.
package fifo_pkg;

   localparam int DEF_DEPTH     = 8;
   localparam int DEF_AF_MARGIN = 2;
   localparam int DEF_AE_LEVEL  = 2;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   typedef logic [ptr_w(DEF_DEPTH)-1:0] ptr_idx_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array with a registered read port.
// The read register is the FIFO output word; the array itself is never reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int DATA_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_we,
   input  logic [ptr_w(DEPTH)-1:0]     i_waddr,
   input  logic [DATA_WIDTH-1:0]       i_wdata,
   input  logic                        i_re,
   input  logic [ptr_w(DEPTH)-1:0]     i_raddr,
   output logic [DATA_WIDTH-1:0]       o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // A read of the slot being overwritten in the same cycle returns the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    o_rdata <= '0;
      else if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with occupancy count and almost-full/almost-empty thresholds.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_thr
   import fifo_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int DATA_WIDTH = 8,
   parameter int AF_LEVEL   = DEPTH - DEF_AF_MARGIN,
   parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wren,
   input  logic [DATA_WIDTH-1:0]       i_data,
   input  logic                        rden,
   output logic [DATA_WIDTH-1:0]       o_data,
   output logic                        o_valid,
   output logic                        full,
   output logic                        empty,
   output logic                        almost_full,
   output logic                        almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   output logic                        overflow,
   output logic                        underflow,
`endif
   output logic [cnt_w(DEPTH)-1:0]     count
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);

   if (AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_levels
      $error("sync_fifo_thr: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
   end

   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic             w_rd_acc;
   logic             w_wr_acc;
   logic [CNT_W-1:0] w_cnt_nxt;

   assign w_rd_acc = rden & ~empty;
   assign w_wr_acc = wren & (~full | w_rd_acc);

   always_comb begin
      w_cnt_nxt = count;
      if (w_wr_acc && !w_rd_acc)      w_cnt_nxt = count + CNT_W'(1);
      else if (w_rd_acc && !w_wr_acc) w_cnt_nxt = count - CNT_W'(1);
   end

   // Flags come from the next count so they line up with count itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         count        <= '0;
         o_valid      <= 1'b0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= (AF_LEVEL == 0);
         almost_empty <= 1'b1;
      end else begin
         if (w_wr_acc) r_wptr <= (r_wptr == LAST_IDX) ? '0 : r_wptr + PTR_W'(1);
         if (w_rd_acc) r_rptr <= (r_rptr == LAST_IDX) ? '0 : r_rptr + PTR_W'(1);
         count        <= w_cnt_nxt;
         o_valid      <= w_rd_acc;
         full         <= (w_cnt_nxt == DEPTH_C);
         empty        <= (w_cnt_nxt == '0);
         almost_full  <= (w_cnt_nxt >= AF_C);
         almost_empty <= (w_cnt_nxt <= AE_C);
      end
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wren & full & ~w_rd_acc) overflow  <= 1'b1;
         if (rden & empty)            underflow <= 1'b1;
      end
   end
`endif

   fifo_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_wr_acc),
      .i_waddr (r_wptr),
      .i_wdata (i_data),
      .i_re    (w_rd_acc),
      .i_raddr (r_rptr),
      .o_rdata (o_data)
   );

endmodule
